encoder_iter: RTL

Iterative, parametrised multi-round successor to the single-round combinational 16-bit encoder. Applies `NUM_ROUNDS` rounds of key-add, 4× `s_box`, `shiftrow` and optional `mixcols` to one 16-bit block per transaction. The block reuses a single round datapath and runs a built-in rotating key schedule. It sits between a valid/ready message source and a valid/ready ciphertext sink.

---
 rtl/encoder_iter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/encoder_iter.sv
// encoder_iter -- iterative multi-round 16-bit block encoder.
//
// Each accepted block goes through NUM_ROUNDS rounds on one shared round
// datapath, one round per clock. A round is:
//   t      = sbox4(state ^ key_r)        (PRESENT 4-bit S-box on every nibble)
//   u      = shiftrow(t)                 (swap nibble 2 with nibble 0)
//   result = m ? mixcols(u) : u          (per byte {a,b} -> {a^b, a})
// The round key is rotated left by one nibble and XORed with the index of
// the next round after every round. With WHITEN set, the key left over
// after the last round is XORed into the ciphertext.
//
// Parameters:
//   NUM_ROUNDS  rounds per block, 1..15
//   LAST_MIX    1: mixcols also in the final round, 0: skipped there
//   WHITEN      1: XOR the post-schedule key into the ciphertext
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     source offers a block
//   in_ready     block can be accepted (combinational from state, out_ready)
//   in_message   plaintext, sampled on accept
//   in_key       key, sampled on accept
//   out_valid    ciphertext available
//   out_ready    sink accepts the ciphertext
//   out_message  ciphertext (registered, held while out_valid && !out_ready)
//   busy         high while rounds are being computed
module encoder_iter #(
  parameter int NUM_ROUNDS = 4,
  parameter int LAST_MIX   = 0,
  parameter int WHITEN     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_message,
  input  logic [15:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_message,
  output logic        busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [15:0] state_q, state_d;
  logic [15:0] key_q, key_d;
  logic [3:0]  round_q, round_d;
  logic [15:0] out_msg_q, out_msg_d;
  logic        out_valid_q, out_valid_d;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // ---------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------
  logic [15:0] key_mixed;
  logic [15:0] sub_out;
  logic [15:0] shift_out;
  logic [15:0] mix_out;
  logic [15:0] round_res;
  logic [15:0] key_next;
  logic [15:0] whiten_key;
  logic        last_round;
  logic        mix_en;

  assign key_mixed = state_q ^ key_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_out[gi*4 +: 4] = sbox4(key_mixed[gi*4 +: 4]);
    end
  endgenerate

  assign shift_out = {sub_out[15:12], sub_out[3:0], sub_out[7:4], sub_out[11:8]};

  // Each byte is a column {hi, lo}; the new column is {hi ^ lo, hi}.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mix
      assign mix_out[gi*8+4 +: 4] = shift_out[gi*8+4 +: 4] ^ shift_out[gi*8 +: 4];
      assign mix_out[gi*8   +: 4] = shift_out[gi*8+4 +: 4];
    end
  endgenerate

  assign last_round = (round_q == LAST_ROUND);
  assign mix_en     = !(last_round && (LAST_MIX == 0));
  assign round_res  = mix_en ? mix_out : shift_out;

  // Key for the next round: rotate left one nibble, fold in the next index.
  assign key_next   = {key_q[11:0], key_q[15:12]} ^ {12'h000, 4'(round_q + 4'd1)};
  // On the final round key_next is the post-schedule key used for whitening.
  assign whiten_key = (WHITEN != 0) ? key_next : 16'h0000;

  // ---------------------------------------------------------------------
  // Handshake outputs
  // ---------------------------------------------------------------------
  // A finished block may hand over and accept the next one in the same
  // cycle, so in_ready follows out_ready while DONE.
  assign in_ready    = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
  assign busy        = (fsm_q == RUN);
  assign out_valid   = out_valid_q;
  assign out_message = out_msg_q;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    round_d     = round_q;
    out_msg_d   = out_msg_q;
    out_valid_d = out_valid_q;

    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_message;
          key_d   = in_key;
          round_d = 4'd0;
          fsm_d   = RUN;
        end
      end

      RUN: begin
        state_d = round_res;
        key_d   = key_next;
        if (last_round) begin
          // Counter parks at 0 so it never runs past the final round index.
          round_d     = 4'd0;
          out_msg_d   = round_res ^ whiten_key;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end else begin
          round_d = 4'(round_q + 4'd1);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            state_d = in_message;
            key_d   = in_key;
            round_d = 4'd0;
            fsm_d   = RUN;
          end else begin
            fsm_d = IDLE;
          end
        end
      end

      default: begin
        fsm_d       = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= 16'h0000;
      key_q       <= 16'h0000;
      round_q     <= 4'd0;
      out_msg_q   <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      round_q     <= round_d;
      out_msg_q   <= out_msg_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
